// File: rtl/voltage_monitor_pkg.sv
// voltage_monitor_pkg: shared FSM encoding, widths and small helpers for the voltage monitor
package voltage_monitor_pkg;
    typedef enum logic [2:0] {IDLE, REQUEST, WAIT, ACCUM, REPORT} state_t;
    localparam int ERR_W = 8;
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction
    function automatic logic alarm_nxt(input logic cur, input logic set, input logic clr);
        return set ? 1'b1 : clr ? 1'b0 : cur;
    endfunction
endpackage

// File: rtl/voltage_monitor_if.sv
// voltage_monitor_if: request/response handshake between the voltage monitor and the I2C read master
interface voltage_monitor_if;
    logic       i2c_enable;
    logic       sample_valid;
    logic [7:0] sample_data;
    logic       sample_error;
    modport master (output i2c_enable, input sample_valid, sample_data, sample_error);
    modport slave  (input i2c_enable, output sample_valid, sample_data, sample_error);
endinterface

// File: rtl/voltage_monitor_block_stats.sv
// voltage_monitor_block_stats: per-block sum/min/max/count accumulator with look-ahead of the next values
module voltage_monitor_block_stats #(
    parameter int AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                acc,
    input  logic [7:0]          sample,
    output logic [7+AVG_LOG2:0] sum_nxt,
    output logic [7:0]          min_nxt,
    output logic [7:0]          max_nxt,
    output logic                last
);
    localparam int SW = 8 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int N = 1 << AVG_LOG2;
    logic [SW-1:0] sum;
    logic [7:0]    min_r, max_r;
    logic [CW-1:0] cnt;
    always_comb begin
        sum_nxt = sum + SW'(sample);
        min_nxt = sample < min_r ? sample : min_r;
        max_nxt = sample > max_r ? sample : max_r;
        last = cnt == CW'(N - 1);
    end
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum   <= '0;
            min_r <= 8'hFF;
            max_r <= 8'h00;
            cnt   <= '0;
        end else if (acc) begin
            sum   <= sum_nxt;
            min_r <= min_nxt;
            max_r <= max_nxt;
            cnt   <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/voltage_monitor.sv
// voltage_monitor: periodic I2C voltage sampler with block averaging, min/max tracking and hysteresis alarms
module voltage_monitor
    import voltage_monitor_pkg::*;
#(
    parameter int         PERIOD_CYCLES  = 1000,
    parameter int         TIMEOUT_CYCLES = 500,
    parameter int         AVG_LOG2       = 2,
    parameter logic [7:0] HI_THR         = 8'd200,
    parameter logic [7:0] LO_THR         = 8'd20,
    parameter logic [7:0] HYST           = 8'd5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    voltage_monitor_if.master bus,
    output logic              avg_valid,
    output logic [7:0]        avg_out,
    output logic [7:0]        min_out,
    output logic [7:0]        max_out,
    output logic              alarm_hi,
    output logic              alarm_lo,
    output logic [ERR_W-1:0]  err_count
);
    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    state_t              state, state_nxt;
    logic [PW-1:0]       pcnt;
    logic [TW-1:0]       tcnt;
    logic [7:0]          sample;
    logic                tick, timeout, err_ev, acc, clr, last;
    logic [7+AVG_LOG2:0] sum_nxt;
    logic [7:0]          min_nxt, max_nxt;

    assign tick = run && pcnt == PW'(PERIOD_CYCLES - 1);
    assign timeout = tcnt == TW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_nxt = state;
        err_ev = 1'b0;
        bus.i2c_enable = state == REQUEST;
        avg_valid = state == REPORT;
        acc = state == ACCUM;
        clr = state == REPORT;
        case (state)
            IDLE:    state_nxt = tick ? REQUEST : IDLE;
            REQUEST: state_nxt = WAIT;
            WAIT: begin
                err_ev = !bus.sample_valid && (bus.sample_error || timeout);
                state_nxt = bus.sample_valid ? ACCUM : err_ev ? IDLE : WAIT;
            end
            ACCUM:   state_nxt = last ? REPORT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    voltage_monitor_block_stats #(.AVG_LOG2(AVG_LOG2)) u_stats (
        .clk(clk), .rst(rst), .clr(clr), .acc(acc), .sample(sample),
        .sum_nxt(sum_nxt), .min_nxt(min_nxt), .max_nxt(max_nxt), .last(last)
    );

    // Results are captured from the stats look-ahead on the final ACCUM edge so they are valid alongside avg_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pcnt      <= '0;
            tcnt      <= '0;
            sample    <= '0;
            avg_out   <= '0;
            min_out   <= '0;
            max_out   <= '0;
            alarm_hi  <= 1'b0;
            alarm_lo  <= 1'b0;
            err_count <= '0;
        end else begin
            state <= state_nxt;
            pcnt  <= (!run || tick) ? '0 : pcnt + 1'b1;
            tcnt  <= (state == WAIT) ? tcnt + 1'b1 : '0;
            if (state == WAIT && bus.sample_valid)
                sample <= bus.sample_data;
            if (err_ev)
                err_count <= sat_inc(err_count);
            if (acc && last) begin
                avg_out <= 8'(sum_nxt >> AVG_LOG2);
                min_out <= min_nxt;
                max_out <= max_nxt;
            end
            if (state == REPORT) begin
                alarm_hi <= alarm_nxt(alarm_hi, avg_out > HI_THR, avg_out < HI_THR - HYST);
                alarm_lo <= alarm_nxt(alarm_lo, avg_out < LO_THR, avg_out > LO_THR + HYST);
            end
        end
    end
endmodule

// File: tb/tb_voltage_monitor.sv
// tb_voltage_monitor: directed self-checking bench for voltage_monitor
module tb_voltage_monitor;
    localparam int P = 20;
    localparam int T = 10;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       avg_valid, alarm_hi, alarm_lo;
    logic [7:0] avg_out, min_out, max_out, err_count;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int av_cnt = 0;
    int en_cnt = 0;
    int t_en = 0;

    voltage_monitor_if bus();

    voltage_monitor #(
        .PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T), .AVG_LOG2(2),
        .HI_THR(8'd200), .LO_THR(8'd20), .HYST(8'd5)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .bus(bus),
        .avg_valid(avg_valid), .avg_out(avg_out), .min_out(min_out), .max_out(max_out),
        .alarm_hi(alarm_hi), .alarm_lo(alarm_lo), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        av_cnt <= av_cnt + int'(avg_valid);
        en_cnt <= en_cnt + int'(bus.i2c_enable);
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_en();
        bit seen = 1'b0;
        for (int i = 0; i < 4 * P && !seen; i++) begin
            @(negedge clk);
            seen = bus.i2c_enable;
        end
        chk("en_seen", int'(seen), 1);
        t_en = cyc;
    endtask

    task automatic feed(input logic [7:0] d, input logic err);
        wait_en();
        @(negedge clk);
        chk("en_one_cycle", int'(bus.i2c_enable), 0);
        bus.sample_valid = 1'b1;
        bus.sample_data = d;
        bus.sample_error = err;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.sample_error = 1'b0;
    endtask

    task automatic block4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        feed(a, 1'b0);
        feed(b, 1'b0);
        feed(c, 1'b0);
        feed(d, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic err_strobe();
        wait_en();
        @(negedge clk);
        bus.sample_error = 1'b1;
        @(negedge clk);
        bus.sample_error = 1'b0;
    endtask

    initial begin
        int a0, e0, t0, g1, g2, g3;
        bus.sample_valid = 1'b0;
        bus.sample_data = 8'd0;
        bus.sample_error = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_i2c_enable", int'(bus.i2c_enable), 0);
        chk("rst_avg_valid", int'(avg_valid), 0);
        chk("rst_avg", int'(avg_out), 0);
        chk("rst_min", int'(min_out), 0);
        chk("rst_max", int'(max_out), 0);
        chk("rst_alarms", int'({alarm_hi, alarm_lo}), 0);
        chk("rst_err", int'(err_count), 0);
        rst = 1'b0;

        e0 = en_cnt;
        repeat (3 * P) @(negedge clk);
        chk("run0_no_request", en_cnt - e0, 0);

        run = 1'b1;
        a0 = av_cnt;
        e0 = en_cnt;
        feed(8'd10, 1'b0);
        t0 = t_en;
        feed(8'd20, 1'b0);
        g1 = t_en - t0;
        t0 = t_en;
        feed(8'd30, 1'b0);
        g2 = t_en - t0;
        t0 = t_en;
        feed(8'd40, 1'b0);
        g3 = t_en - t0;
        @(negedge clk);
        chk("t1_latency_avg_valid", int'(avg_valid), 1);
        chk("t1_avg", int'(avg_out), 25);
        chk("t1_min", int'(min_out), 10);
        chk("t1_max", int'(max_out), 40);
        repeat (3) @(negedge clk);
        chk("t1_avg_valid_count", av_cnt - a0, 1);
        chk("t1_en_pulses", en_cnt - e0, 4);
        chk("t1_gap1", g1, P);
        chk("t1_gap2", g2, P);
        chk("t1_gap3", g3, P);
        chk("t1_alarms", int'({alarm_hi, alarm_lo}), 0);

        block4(8'd255, 8'd255, 8'd255, 8'd255);
        chk("t2_avg_255", int'(avg_out), 255);
        chk("t2_min_255", int'(min_out), 255);
        chk("t2_hi_set", int'(alarm_hi), 1);
        block4(8'd196, 8'd196, 8'd196, 8'd196);
        chk("t2_avg_196", int'(avg_out), 196);
        chk("t2_hi_hold", int'(alarm_hi), 1);
        block4(8'd194, 8'd194, 8'd194, 8'd194);
        chk("t2_hi_clear", int'(alarm_hi), 0);

        block4(8'd10, 8'd10, 8'd10, 8'd10);
        chk("t3_lo_set", int'(alarm_lo), 1);
        block4(8'd24, 8'd24, 8'd24, 8'd24);
        chk("t3_avg_24", int'(avg_out), 24);
        chk("t3_lo_hold", int'(alarm_lo), 1);
        block4(8'd26, 8'd26, 8'd26, 8'd26);
        chk("t3_lo_clear", int'(alarm_lo), 0);
        chk("t3_hi_idle", int'(alarm_hi), 0);

        a0 = av_cnt;
        e0 = int'(err_count);
        feed(8'd50, 1'b0);
        repeat (2) @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.sample_data = 8'd0;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        feed(8'd60, 1'b0);
        feed(8'd70, 1'b0);
        feed(8'd80, 1'b1);
        @(negedge clk);
        chk("t5_avg_valid", int'(avg_valid), 1);
        chk("t5_avg", int'(avg_out), 65);
        chk("t5_min_stray_ignored", int'(min_out), 50);
        chk("t5_max", int'(max_out), 80);
        repeat (3) @(negedge clk);
        chk("t5_err_unchanged", int'(err_count), e0);
        chk("t5_avg_valid_count", av_cnt - a0, 1);

        a0 = av_cnt;
        wait_en();
        repeat (T) @(negedge clk);
        chk("t4_err_before_timeout", int'(err_count), 0);
        @(negedge clk);
        chk("t4_err_timeout", int'(err_count), 1);
        err_strobe();
        @(negedge clk);
        chk("t4_err_strobe", int'(err_count), 2);
        for (int i = 0; i < 298; i++) err_strobe();
        @(negedge clk);
        chk("t4_err_saturate", int'(err_count), 255);
        chk("t4_no_avg_valid", av_cnt - a0, 0);

        feed(8'd100, 1'b0);
        feed(8'd100, 1'b0);
        feed(8'd100, 1'b0);
        wait_en();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_avg", int'(avg_out), 0);
        chk("t6_rst_minmax", int'({min_out, max_out}), 0);
        chk("t6_rst_err", int'(err_count), 0);
        chk("t6_rst_flags", int'({avg_valid, alarm_hi, alarm_lo, bus.i2c_enable}), 0);
        a0 = av_cnt;
        feed(8'd40, 1'b0);
        feed(8'd40, 1'b0);
        feed(8'd40, 1'b0);
        repeat (3) @(negedge clk);
        chk("t6_no_early_block", av_cnt - a0, 0);
        feed(8'd40, 1'b0);
        @(negedge clk);
        chk("t6_avg_valid", int'(avg_valid), 1);
        chk("t6_avg_fresh", int'(avg_out), 40);
        chk("t6_min_fresh", int'(min_out), 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
